spi_xfer: RTL and testbench

Parametrised full-duplex SPI mode-0 transfer engine for the SD card path. It generates SCLK from the system clock with a selectable slow or fast divider, for card initialisation and data phases respectively. It shifts out a DATA_W-bit word on MOSI while capturing MISO, and returns the received word with a one-cycle done strobe. It sits between the SD command/data sequencer and the card pins; chip-select stays under sequencer control.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_half_tick.sv | 45 ++++
 rtl/spi_xfer.sv | 162 ++++++++++++++++
 tb/tb_spi_xfer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default constants for the SPI transfer engine.
// Holds the FSM state encoding, SD divider defaults and a small helper.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } state_e;

   localparam int SPI_DATA_W = 8;
   // 400 kHz SCLK for card init from a ~51.2 MHz system clock
   localparam int SPI_HALF_SLOW = 64;
   localparam int SPI_HALF_FAST = 2;

   function automatic int spi_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period counter: counts while en, wraps at terminal count.
// Ports: clk, rst, en, clr, sel_slow (divider select), tc (terminal count).
module spi_half_tick
   import spi_pkg::*;
#(
   parameter int HALF_SLOW = SPI_HALF_SLOW,
   parameter int HALF_FAST = SPI_HALF_FAST,
   parameter int CNT_W     = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   input  logic sel_slow,
   output logic tc
);

   localparam logic [CNT_W-1:0] TC_SLOW = CNT_W'(HALF_SLOW - 1);
   localparam logic [CNT_W-1:0] TC_FAST = CNT_W'(HALF_FAST - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      tc = sel_slow ? (cnt_q == TC_SLOW) : (cnt_q == TC_FAST);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr || (en && tc)) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_xfer.sv
// Full-duplex SPI mode-0 word transfer engine with slow/fast SCLK divider.
// Ports: start/slow_mode/tx_data in, ready/done/rx_data out, sclk/mosi/miso pins.
module spi_xfer
   import spi_pkg::*;
#(
   parameter int DATA_W        = SPI_DATA_W,
   parameter int HALF_DIV_SLOW = SPI_HALF_SLOW,
   parameter int HALF_DIV_FAST = SPI_HALF_FAST,
   parameter bit MSB_FIRST     = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              slow_mode,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              miso,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sclk,
   output logic              mosi
);

   localparam int HALF_MAX = spi_max(HALF_DIV_SLOW, HALF_DIV_FAST);
   localparam int CNT_W    = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
   localparam int BIT_W    = $clog2(DATA_W);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic              slow_q, slow_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              done_q, done_d;
   logic              ready_q, ready_d;
   logic              accept;
   logic              tick;
   logic [DATA_W-1:0] tx_nxt;

   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? w[DATA_W-1] : w[0];
   endfunction

   assign accept = start & ready_q;

   spi_half_tick #(
      .HALF_SLOW (HALF_DIV_SLOW),
      .HALF_FAST (HALF_DIV_FAST),
      .CNT_W     (CNT_W)
   ) u_tick (
      .clk      (clk),
      .rst      (rst),
      .en       (state_q != ST_IDLE),
      .clr      (state_q == ST_IDLE),
      .sel_slow (slow_q),
      .tc       (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         bit_q     <= '0;
         slow_q    <= 1'b0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b1;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rx_data_q <= rx_data_d;
         bit_q     <= bit_d;
         slow_q    <= slow_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = ST_LOW;
         ST_LOW:  if (tick) state_d = ST_HIGH;
         ST_HIGH: begin
            if (tick) begin
               state_d = (bit_q == '0) ? ST_IDLE : ST_LOW;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_d      = tx_q;
      rx_d      = rx_q;
      rx_data_d = rx_data_q;
      bit_d     = bit_q;
      slow_d    = slow_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      done_d    = 1'b0;
      ready_d   = ready_q;
      tx_nxt    = MSB_FIRST ? {tx_q[DATA_W-2:0], 1'b0}
                            : {1'b0, tx_q[DATA_W-1:1]};
      unique case (state_q)
         ST_IDLE: begin
            sclk_d  = 1'b0;
            mosi_d  = 1'b1;
            ready_d = 1'b1;
            if (accept) begin
               tx_d    = tx_data;
               slow_d  = slow_mode;
               bit_d   = BIT_W'(DATA_W - 1);
               mosi_d  = first_bit(tx_data);
               ready_d = 1'b0;
            end
         end
         ST_LOW: begin
            if (tick) begin
               sclk_d = 1'b1;
               rx_d   = MSB_FIRST ? {rx_q[DATA_W-2:0], miso}
                                  : {miso, rx_q[DATA_W-1:1]};
            end
         end
         ST_HIGH: begin
            if (tick) begin
               sclk_d = 1'b0;
               if (bit_q == '0) begin
                  rx_data_d = rx_q;
                  done_d    = 1'b1;
                  mosi_d    = 1'b1;
                  ready_d   = 1'b1;
               end else begin
                  tx_d   = tx_nxt;
                  mosi_d = first_bit(tx_nxt);
                  bit_d  = bit_q - 1'b1;
               end
            end
         end
         default: begin
            sclk_d  = 1'b0;
            mosi_d  = 1'b1;
            ready_d = 1'b1;
         end
      endcase
   end

   assign ready   = ready_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_xfer.sv
// Directed scoreboard bench for spi_xfer: 8-bit MSB-first and 16-bit LSB-first.
// A card model drives miso; monitors rebuild the mosi word and SCLK phases.
module tb_spi_xfer;

   localparam int HF = 2;
   localparam int HS = 64;

   typedef struct {
      logic [15:0] tx;
      logic [15:0] rx;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   logic        start_a, slow_a, miso_a;
   logic [7:0]  tx_a, rx_a, card_a;
   logic        ready_a, done_a, sclk_a, mosi_a;
   logic        start_b, slow_b, miso_b;
   logic [15:0] tx_b, rx_b, card_b;
   logic        ready_b, done_b, sclk_b, mosi_b;

   spi_xfer dut_a (
      .clk(clk), .rst(rst), .start(start_a), .slow_mode(slow_a),
      .tx_data(tx_a), .miso(miso_a), .ready(ready_a), .done(done_a),
      .rx_data(rx_a), .sclk(sclk_a), .mosi(mosi_a)
   );

   spi_xfer #(.DATA_W(16), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .slow_mode(slow_b),
      .tx_data(tx_b), .miso(miso_b), .ready(ready_b), .done(done_b),
      .rx_data(rx_b), .sclk(sclk_b), .mosi(mosi_b)
   );

   // card model: next bit after every falling SCLK, restarted on accept
   logic [4:0]  fall_a = '0, fall_b = '0;
   logic [7:0]  mon_a = '0;
   logic [15:0] mon_b = '0;
   logic        sp_a = 1'b0, sp_b = 1'b0, rp_a = 1'b0, rp_b = 1'b0;
   int          last_rise_a = 0, per_a = 0;
   int          hi_b = 0, lo_b = 0, min_hi_b = 1000, min_lo_b = 1000;

   assign miso_a = card_a[3'(5'd7 - fall_a)];
   assign miso_b = card_b[fall_b[3:0]];

   always @(negedge clk) begin
      sp_a <= sclk_a;
      rp_a <= ready_a;
      if (rp_a && !ready_a) begin
         fall_a <= '0;
         mon_a  <= '0;
      end else begin
         if (sp_a && !sclk_a) fall_a <= fall_a + 5'd1;
         if (!sp_a && sclk_a) begin
            mon_a       <= {mon_a[6:0], mosi_a};
            per_a       <= cyc - last_rise_a;
            last_rise_a <= cyc;
         end
      end
   end

   always @(negedge clk) begin
      sp_b <= sclk_b;
      rp_b <= ready_b;
      if (!sp_b && sclk_b) begin
         if (lo_b < min_lo_b) min_lo_b <= lo_b;
         hi_b <= 1;
      end else if (sp_b && !sclk_b) begin
         if (hi_b < min_hi_b) min_hi_b <= hi_b;
         lo_b <= 1;
      end else if (sclk_b) begin
         hi_b <= hi_b + 1;
      end else begin
         lo_b <= lo_b + 1;
      end
      if (rp_b && !ready_b) begin
         fall_b <= '0;
         mon_b  <= '0;
      end else begin
         if (sp_b && !sclk_b) fall_b <= fall_b + 5'd1;
         if (!sp_b && sclk_b) mon_b <= {mosi_b, mon_b[15:1]};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic go_a(input logic [7:0] tx, input logic slow,
                       input logic [7:0] card, input bit push,
                       output int acc);
      @(negedge clk);
      start_a = 1'b1;
      tx_a    = tx;
      slow_a  = slow;
      card_a  = card;
      if (push) q_a.push_back('{tx: 16'(tx), rx: 16'(card)});
      @(negedge clk);
      start_a = 1'b0;
      acc     = cyc;
   endtask

   task automatic wait_done(input bit b, input int lim, output int at);
      at = -1;
      for (int n = 0; n < lim; n++) begin
         @(negedge clk);
         if ((b ? done_b : done_a) === 1'b1) begin
            at = cyc;
            break;
         end
      end
      chk("done_timeout", 32'(at >= 0), 32'd1);
   endtask

   task automatic pop_a(input string tag);
      exp_t e;
      chk({tag, "_sb"}, 32'(q_a.size() > 0), 32'd1);
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         chk({tag, "_rx"}, 32'(rx_a), 32'(e.rx[7:0]));
         chk({tag, "_mosi"}, 32'(mon_a), 32'(e.tx[7:0]));
      end
   endtask

   task automatic pop_b(input string tag);
      exp_t e;
      chk({tag, "_sb"}, 32'(q_b.size() > 0), 32'd1);
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         chk({tag, "_rx"}, 32'(rx_b), 32'(e.rx));
         chk({tag, "_mosi"}, 32'(mon_b), 32'(e.tx));
      end
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_ready"}, 32'(ready_a), 32'd1);
      chk({tag, "_done"}, 32'(done_a), 32'd0);
      chk({tag, "_sclk"}, 32'(sclk_a), 32'd0);
      chk({tag, "_mosi"}, 32'(mosi_a), 32'd1);
      chk({tag, "_rx"}, 32'(rx_a), 32'd0);
   endtask

   initial begin
      int acc, at, d1, d2, nd;
      rst = 1'b1;
      start_a = 1'b0; slow_a = 1'b0; tx_a = '0; card_a = '0;
      start_b = 1'b0; slow_b = 1'b0; tx_b = '0; card_b = '0;
      repeat (3) @(negedge clk);
      idle_chk("rst");
      chk("rst_b_ready", 32'(ready_b), 32'd1);
      chk("rst_b_rx", 32'(rx_b), 32'd0);
      rst = 1'b0;

      // fast mode, 0xA5 out, 0x3C back
      go_a(8'hA5, 1'b0, 8'h3C, 1'b1, acc);
      chk("fast_first_bit", 32'(mosi_a), 32'd1);
      wait_done(1'b0, 100, at);
      chk("fast_lat", 32'(at - acc), 32'(2 * HF * 8));
      chk("fast_ready", 32'(ready_a), 32'd1);
      pop_a("fast");
      @(negedge clk);
      chk("fast_done_1cyc", 32'(done_a), 32'd0);
      chk("fast_rx_hold", 32'(rx_a), 32'h3C);

      // slow mode, all ones
      go_a(8'hFF, 1'b1, 8'h81, 1'b1, acc);
      wait_done(1'b0, 2000, at);
      chk("slow_lat", 32'(at - acc), 32'(2 * HS * 8));
      chk("slow_period", 32'(per_a), 32'(2 * HS));
      pop_a("slow");

      // start during a transfer is ignored
      go_a(8'h96, 1'b0, 8'h5B, 1'b1, acc);
      repeat (10) @(negedge clk);
      start_a = 1'b1;
      tx_a    = 8'h00;
      slow_a  = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("ign_busy", 32'(ready_a), 32'd0);
      wait_done(1'b0, 100, at);
      chk("ign_lat", 32'(at - acc), 32'(2 * HF * 8));
      pop_a("ign");
      nd = 0;
      repeat (80) begin
         @(negedge clk);
         if (done_a) nd++;
      end
      chk("ign_one_done", 32'(nd), 32'd0);

      // reset mid-transfer
      go_a(8'hC3, 1'b0, 8'h77, 1'b0, acc);
      repeat (13) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      idle_chk("mid_rst");
      rst = 1'b0;
      nd = 0;
      repeat (60) begin
         @(negedge clk);
         if (done_a) nd++;
      end
      chk("mid_rst_no_done", 32'(nd), 32'd0);
      go_a(8'h5A, 1'b0, 8'hE1, 1'b1, acc);
      wait_done(1'b0, 100, at);
      chk("post_rst_lat", 32'(at - acc), 32'(2 * HF * 8));
      pop_a("post_rst");

      // 16-bit LSB-first back-to-back
      @(negedge clk);
      start_b = 1'b1;
      tx_b    = 16'h1234;
      card_b  = 16'hC35A;
      q_b.push_back('{tx: 16'h1234, rx: 16'hC35A});
      @(negedge clk);
      start_b = 1'b0;
      acc     = cyc;
      wait_done(1'b1, 200, d1);
      chk("b2b_lat", 32'(d1 - acc), 32'(2 * HF * 16));
      pop_b("b2b_1");
      start_b = 1'b1;
      tx_b    = 16'hABCD;
      card_b  = 16'h9E21;
      q_b.push_back('{tx: 16'hABCD, rx: 16'h9E21});
      @(negedge clk);
      start_b = 1'b0;
      chk("b2b_accept", 32'(ready_b), 32'd0);
      wait_done(1'b1, 200, d2);
      chk("b2b_gap", 32'(d2 - d1), 32'(2 * HF * 16 + 1));
      pop_b("b2b_2");
      chk("b2b_min_hi", 32'(min_hi_b), 32'(HF));
      chk("b2b_min_lo", 32'(min_lo_b), 32'(HF));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
